// File: rtl/pb_debouncer_if.sv
// Signal bundle between a pushbutton debouncer and its consumer.
// longPress exists only when LONG_PRESS_EN is defined.
interface pb_debouncer_if;
  logic       pbRaw;
  logic       pbClean;
  logic       busy;
  logic [7:0] bounceCnt;
`ifdef LONG_PRESS_EN
  logic       longPress;
`endif

  modport master (
    output pbRaw,
    input  pbClean,
    input  busy,
    input  bounceCnt
`ifdef LONG_PRESS_EN
    , input longPress
`endif
  );

  modport slave (
    input  pbRaw,
    output pbClean,
    output busy,
    output bounceCnt
`ifdef LONG_PRESS_EN
    , output longPress
`endif
  );
endinterface

// File: rtl/pb_debouncer.sv
// Pushbutton debouncer: 2-flop synchronizer, 4-state qualification FSM, bounce counter.
// Optional long-press detector enabled by defining LONG_PRESS_EN.
module pb_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES     = 64
) (
  input  logic          clock,
  input  logic          reset,
  pb_debouncer_if.slave pb
);
  localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] One     = CntW'(1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_LOW,
    CHK_HIGH,
    IDLE_HIGH,
    CHK_LOW
  } stateT;

  stateT           state, stateNext;
  logic [CntW-1:0] counter, counterNext;
  logic            sync1, sync2;
  logic            cleanQ, cleanNext;
  logic            busyQ, busyNext;
  logic [7:0]      bounceQ;
  logic            bounceEvent;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      state   <= IDLE_LOW;
      counter <= '0;
      cleanQ  <= 1'b0;
      busyQ   <= 1'b0;
      bounceQ <= '0;
    end else begin
      sync1   <= pb.pbRaw;
      sync2   <= sync1;
      state   <= stateNext;
      counter <= counterNext;
      cleanQ  <= cleanNext;
      busyQ   <= busyNext;
      if (bounceEvent && bounceQ != 8'hFF) bounceQ <= bounceQ + 8'd1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    cleanNext   = cleanQ;
    bounceEvent = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (sync2) begin
          stateNext   = CHK_HIGH;
          counterNext = One;
        end
      end
      CHK_HIGH: begin
        if (!sync2) begin
          stateNext   = IDLE_LOW;
          counterNext = '0;
          bounceEvent = 1'b1;
        end else if (counter == LastCnt) begin
          stateNext   = IDLE_HIGH;
          counterNext = '0;
          cleanNext   = 1'b1;
        end else begin
          counterNext = counter + One;
        end
      end
      IDLE_HIGH: begin
        if (!sync2) begin
          stateNext   = CHK_LOW;
          counterNext = One;
        end
      end
      CHK_LOW: begin
        if (sync2) begin
          stateNext   = IDLE_HIGH;
          counterNext = '0;
          bounceEvent = 1'b1;
        end else if (counter == LastCnt) begin
          stateNext   = IDLE_LOW;
          counterNext = '0;
          cleanNext   = 1'b0;
        end else begin
          counterNext = counter + One;
        end
      end
      default: begin
        stateNext   = IDLE_LOW;
        counterNext = '0;
      end
    endcase
    // busy is registered from the next state so it lines up with the state register.
    busyNext = (stateNext == CHK_HIGH) || (stateNext == CHK_LOW);
  end

  assign pb.pbClean   = cleanQ;
  assign pb.busy      = busyQ;
  assign pb.bounceCnt = bounceQ;

`ifdef LONG_PRESS_EN
  localparam logic [CntW-1:0] LongCnt = CntW'(LONG_CYCLES);

  logic [CntW-1:0] holdCnt;
  logic            longQ;

  // Counts only while settled high; an aborted release leaves the count and flag alone.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      holdCnt <= '0;
      longQ   <= 1'b0;
    end else if (state == CHK_LOW && stateNext == IDLE_LOW) begin
      holdCnt <= '0;
      longQ   <= 1'b0;
    end else if (state == IDLE_HIGH && holdCnt != LongCnt) begin
      holdCnt <= holdCnt + One;
      if (holdCnt + One == LongCnt) longQ <= 1'b1;
    end
  end

  assign pb.longPress = longQ;
`endif
endmodule

// File: tb/tb_pb_debouncer.sv
// Scoreboard bench for pb_debouncer: run-length reference model feeds a queue,
// a negedge monitor pops and compares; directed tasks cover latency and limits.
module tb_pb_debouncer;
  localparam int N  = 4;
  localparam int LC = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  pb_debouncer_if pb();

  pb_debouncer #(.DEBOUNCE_CYCLES(N), .LONG_CYCLES(LC)) dut (
    .clock(clock),
    .reset(reset),
    .pb   (pb)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clean;
    logic       busy;
    logic [7:0] bounce;
    logic       lp;
  } expT;

  expT sbQ[$];
  int  tests = 0;
  int  fails = 0;
  int  edgeNum = 0;
  int  riseCount = 0;
  bit  cleanSeen = 0;
  bit  prevClean = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: sync2 is the raw level sampled two edges earlier; the clean level
  // flips once that level has differed from it for N consecutive samples.
  bit rawQ[$] = '{1'b0, 1'b0};
  bit mClean = 0, mLong = 0;
  int mRun = 0, mBounce = 0, mHold = 0;

  always @(posedge clock) begin
    expT e;
    bit  s, idleHigh;
    edgeNum++;
    if (!reset) begin
      rawQ = '{1'b0, 1'b0};
      mClean = 0; mLong = 0; mRun = 0; mBounce = 0; mHold = 0;
    end else begin
      s = rawQ.pop_front();
      rawQ.push_back(pb.pbRaw);
      idleHigh = mClean && (mRun == 0);
      if (idleHigh && mHold < LC) begin
        mHold++;
        if (mHold == LC) mLong = 1;
      end
      if (s != mClean) begin
        mRun++;
        if (mRun == N) begin
          mClean = s;
          mRun   = 0;
          if (!s) begin mHold = 0; mLong = 0; end
        end
      end else begin
        if (mRun > 0 && mBounce < 255) mBounce++;
        mRun = 0;
      end
    end
    e.clean  = mClean;
    e.busy   = (mRun > 0);
    e.bounce = 8'(mBounce);
    e.lp     = mLong;
    sbQ.push_back(e);
  end

  always @(negedge clock) begin
    expT e;
    if (pb.pbClean && !prevClean) riseCount++;
    prevClean = pb.pbClean;
    if (pb.pbClean) cleanSeen = 1;
    if (!reset) begin
      sbQ.delete();
      check("rst.pbClean", pb.pbClean, 0);
      check("rst.busy", pb.busy, 0);
      check("rst.bounceCnt", pb.bounceCnt, 0);
`ifdef LONG_PRESS_EN
      check("rst.longPress", pb.longPress, 0);
`endif
    end else if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      check("sb.pbClean", pb.pbClean, e.clean);
      check("sb.busy", pb.busy, e.busy);
      check("sb.bounceCnt", pb.bounceCnt, e.bounce);
`ifdef LONG_PRESS_EN
      check("sb.longPress", pb.longPress, e.lp);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // sel 0 = pbClean, 1 = busy; returns the edge at which the level appeared, or -1.
  task automatic waitOut(input int sel, input logic level, input int budget, output int at);
    logic v;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      v = (sel == 0) ? pb.pbClean : pb.busy;
      if (v == level) begin
        at = edgeNum;
        break;
      end
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL wait.timeout: sel %0d never reached %0d within %0d cycles", sel, level, budget);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, busyAt, riseAt, fallAt, lpAt, r0, x, rel;
    pb.pbRaw = 1'b0;
    reset = 1'b0;
    tick(3);
    check("reset.pbClean", pb.pbClean, 0);
    check("reset.bounceCnt", pb.bounceCnt, 0);
    reset = 1'b1;
    tick(5);

    // Latency of both transitions, high time, single downstream pulse.
    r0 = riseCount;
    lpAt = -1;
    pb.pbRaw = 1'b1;
    k = edgeNum + 1;
    waitOut(1, 1'b1, 20, busyAt);
    check("lat.busyRise", busyAt, k + 2);
    waitOut(0, 1'b1, 20, riseAt);
    check("lat.cleanRise", riseAt, k + N + 1);
    check("lat.busyAtRise", pb.busy, 0);
    while (edgeNum < k + 19) begin
      tick(1);
`ifdef LONG_PRESS_EN
      if (lpAt < 0 && pb.longPress) lpAt = edgeNum;
`endif
    end
    pb.pbRaw = 1'b0;
    waitOut(0, 1'b0, 20, fallAt);
    check("lat.cleanFall", fallAt, k + 20 + N + 1);
    check("lat.highTime", fallAt - riseAt, 20);
`ifdef LONG_PRESS_EN
    check("lat.longPressEdge", lpAt, riseAt + LC);
    check("lat.longPressCleared", pb.longPress, 0);
`endif
    tick(3);
    check("pulser.count", riseCount - r0, 1);

    // Three-sample pulse is one bounce and no toggle.
    pb.pbRaw = 1'b1;
    tick(3);
    pb.pbRaw = 1'b0;
    tick(10);
    check("short.bounceCnt", pb.bounceCnt, 1);
    check("short.pbClean", pb.pbClean, 0);
    check("short.busy", pb.busy, 0);

    // Single-sample glitch while settled high.
    pb.pbRaw = 1'b1;
    waitOut(0, 1'b1, 20, x);
    tick(2);
    pb.pbRaw = 1'b0;
    tick(1);
    pb.pbRaw = 1'b1;
    tick(10);
    check("glitchHigh.bounceCnt", pb.bounceCnt, 2);
    check("glitchHigh.pbClean", pb.pbClean, 1);
    pb.pbRaw = 1'b0;
    waitOut(0, 1'b0, 20, x);
    check("glitchHigh.bounceAfterRelease", pb.bounceCnt, 2);

    // Reset in the middle of a qualification.
    pb.pbRaw = 1'b1;
    tick(4);
    check("rstq.busyBefore", pb.busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("rstq.asyncPbClean", pb.pbClean, 0);
    check("rstq.asyncBusy", pb.busy, 0);
    check("rstq.asyncBounceCnt", pb.bounceCnt, 0);
`ifdef LONG_PRESS_EN
    check("rstq.asyncLongPress", pb.longPress, 0);
`endif
    tick(2);
    reset = 1'b1;
    rel = edgeNum + 1;
    waitOut(0, 1'b1, 20, x);
    check("rstq.freshRise", x, rel + N + 1);
    check("rstq.bounceCnt", pb.bounceCnt, 0);
    pb.pbRaw = 1'b0;
    waitOut(0, 1'b0, 20, x);

`ifdef LONG_PRESS_EN
    // Long press survives a short release glitch, clears with a real release.
    pb.pbRaw = 1'b1;
    waitOut(0, 1'b1, 20, riseAt);
    lpAt = -1;
    repeat (15) begin
      tick(1);
      if (lpAt < 0 && pb.longPress) lpAt = edgeNum;
    end
    check("lp.assertEdge", lpAt, riseAt + LC);
    pb.pbRaw = 1'b0;
    tick(2);
    pb.pbRaw = 1'b1;
    tick(8);
    check("lp.afterGlitch", pb.longPress, 1);
    check("lp.cleanAfterGlitch", pb.pbClean, 1);
    pb.pbRaw = 1'b0;
    waitOut(0, 1'b0, 20, fallAt);
    check("lp.clearWithClean", pb.longPress, 0);
    tick(5);
`endif

    // Random run lengths, checked by the scoreboard.
    repeat (250) begin
      pb.pbRaw = 1'($urandom_range(0, 1));
      tick($urandom_range(1, 8));
    end
    pb.pbRaw = 1'b0;
    tick(12);

    // Saturation of the bounce counter.
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(3);
    cleanSeen = 0;
    repeat (300) begin
      pb.pbRaw = 1'b1;
      tick(1);
      pb.pbRaw = 1'b0;
      tick(4);
    end
    tick(5);
    check("sat.bounceCnt", pb.bounceCnt, 255);
    check("sat.pbCleanNeverHigh", cleanSeen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
